// File: rtl/vram_pkg.sv
// rtl/vram_pkg.sv - shared VRAM arbitration state encoding and default bus widths
package vram_pkg;

    localparam int ADDR_W_DEF    = 16;
    localparam int DATA_W_DEF    = 8;
    localparam int VGA_BURST_DEF = 8;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] VGA_RD  = 2'd1;
    localparam logic [1:0] CPU_ACC = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE    = IDLE,
        S_VGA_RD  = VGA_RD,
        S_CPU_ACC = CPU_ACC
    } arb_state_t;

endpackage

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - single-port VRAM arbiter: VGA burst reads vs CPU single accesses
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int VGA_BURST = VGA_BURST_DEF
) (
    input  logic              CLOCK_50,
    input  logic              rst_n,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic              vga_grant,
    output logic [DATA_W-1:0] vga_rdata,
    output logic              vga_rvalid,
    output logic              vga_done,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ready,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rvalid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [ADDR_W-1:0] LAST_CNT = ADDR_W'(VGA_BURST - 1);

    arb_state_t        state, state_n;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] cnt;
    logic              last_vga;
    logic              rv_vga, rv_last, rv_cpu;
    logic              pick_vga;
    logic              burst_end;

    // VGA yields to a waiting CPU only right after it finished a burst
    assign pick_vga  = vga_req && !(cpu_req && last_vga);
    assign burst_end = (state == S_VGA_RD) && (cnt == LAST_CNT);

    always_comb begin
        state_n   = state;
        vga_grant = 1'b0;
        cpu_ready = 1'b0;
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        case (state)
            S_IDLE: begin
                if (pick_vga)
                    state_n = S_VGA_RD;
                else if (cpu_req)
                    state_n = S_CPU_ACC;
            end
            S_VGA_RD: begin
                mem_addr  = base + cnt;
                vga_grant = (cnt == '0);
                if (cnt == LAST_CNT)
                    state_n = S_IDLE;
            end
            S_CPU_ACC: begin
                state_n = S_IDLE;
                if (cpu_req) begin
                    mem_addr  = cpu_addr;
                    mem_we    = cpu_we;
                    mem_wdata = cpu_wdata;
                    cpu_ready = 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            base     <= '0;
            cnt      <= '0;
            last_vga <= 1'b0;
            rv_vga   <= 1'b0;
            rv_last  <= 1'b0;
            rv_cpu   <= 1'b0;
        end else begin
            state <= state_n;
            if (state == S_IDLE && pick_vga) begin
                base <= vga_addr;
                cnt  <= '0;
            end else if (state == S_VGA_RD) begin
                cnt <= cnt + ADDR_W'(1);
            end
            if (burst_end)
                last_vga <= 1'b1;
            else if (state == S_CPU_ACC)
                last_vga <= 1'b0;
            // return tags line up with the synchronous RAM's one-cycle read latency
            rv_vga  <= (state == S_VGA_RD);
            rv_last <= burst_end;
            rv_cpu  <= cpu_ready && !cpu_we;
        end
    end

    assign vga_rvalid = rv_vga;
    assign vga_done   = rv_vga && rv_last;
    assign cpu_rvalid = rv_cpu;
    assign vga_rdata  = rv_vga ? mem_rdata : '0;
    assign cpu_rdata  = rv_cpu ? mem_rdata : '0;

endmodule

// File: tb/tb_vram_arbiter.sv
// tb/tb_vram_arbiter.sv - directed self-checking bench for vram_arbiter
module tb_vram_arbiter;

    logic        CLOCK_50 = 1'b0;
    logic        rst_n;
    logic        vga_req;
    logic [15:0] vga_addr;
    logic        vga_grant;
    logic [7:0]  vga_rdata;
    logic        vga_rvalid;
    logic        vga_done;
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_ready;
    logic [7:0]  cpu_rdata;
    logic        cpu_rvalid;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    logic [7:0]  ram [logic [15:0]];
    logic [45:0] all_out;

    int n_vec = 0;
    int n_err = 0;

    vram_arbiter #(.ADDR_W(16), .DATA_W(8), .VGA_BURST(8)) dut (
        .CLOCK_50   (CLOCK_50),
        .rst_n      (rst_n),
        .vga_req    (vga_req),
        .vga_addr   (vga_addr),
        .vga_grant  (vga_grant),
        .vga_rdata  (vga_rdata),
        .vga_rvalid (vga_rvalid),
        .vga_done   (vga_done),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_ready  (cpu_ready),
        .cpu_rdata  (cpu_rdata),
        .cpu_rvalid (cpu_rvalid),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // Unwritten locations read back as the low byte of their address
    always @(posedge CLOCK_50) begin
        mem_rdata <= ram.exists(mem_addr) ? ram[mem_addr] : mem_addr[7:0];
        if (mem_we)
            ram[mem_addr] = mem_wdata;
    end

    assign all_out = {vga_grant, vga_rvalid, vga_done, vga_rdata, cpu_ready, cpu_rvalid,
                      cpu_rdata, mem_we, mem_addr, mem_wdata};

    task automatic test_reset();
        rst_n = 1'b0; vga_req = 1'b0; vga_addr = '0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        repeat (2) @(negedge CLOCK_50);
        n_vec++;
        if (all_out !== 46'd0) begin
            n_err++; $display("FAIL reset_hold got %h expected 0", all_out);
        end
        rst_n = 1'b1;
        @(negedge CLOCK_50);
        n_vec++;
        if (all_out !== 46'd0) begin
            n_err++; $display("FAIL reset_release got %h expected 0", all_out);
        end
    endtask

    task automatic test_vga_burst();
        logic [27:0] exp, got;
        for (int c = 0; c <= 10; c++) begin
            @(posedge CLOCK_50); #1;
            if (c == 0) begin vga_req = 1'b1; vga_addr = 16'h0100; end
            if (c == 2) vga_req = 1'b0;
            @(negedge CLOCK_50);
            exp = {c == 1, c >= 2 && c <= 9, c == 9, (c >= 2 && c <= 9) ? 8'(c - 2) : 8'h00,
                   1'b0, (c >= 1 && c <= 8) ? 16'(16'h0100 + c - 1) : 16'h0000};
            got = {vga_grant, vga_rvalid, vga_done, vga_rdata, mem_we, mem_addr};
            n_vec++;
            if (got !== exp) begin
                n_err++; $display("FAIL vga_burst c=%0d got %h expected %h", c, got, exp);
            end
        end
    endtask

    task automatic test_cpu_write_read();
        logic [35:0] exp, got;
        for (int c = 0; c <= 6; c++) begin
            @(posedge CLOCK_50); #1;
            case (c)
                0: begin cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h1234; cpu_wdata = 8'hA5; end
                2: cpu_req = 1'b0;
                3: begin cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h1234; cpu_wdata = 8'h00; end
                5: cpu_req = 1'b0;
                default: ;
            endcase
            @(negedge CLOCK_50);
            case (c)
                1:       exp = {1'b1, 1'b0, 8'h00, 1'b1, 16'h1234, 8'hA5, 1'b0};
                4:       exp = {1'b1, 1'b0, 8'h00, 1'b0, 16'h1234, 8'h00, 1'b0};
                5:       exp = {1'b0, 1'b1, 8'hA5, 1'b0, 16'h0000, 8'h00, 1'b0};
                default: exp = 36'd0;
            endcase
            got = {cpu_ready, cpu_rvalid, cpu_rdata, mem_we, mem_addr, mem_wdata, vga_rvalid};
            n_vec++;
            if (got !== exp) begin
                n_err++; $display("FAIL cpu_write_read c=%0d got %h expected %h", c, got, exp);
            end
        end
    endtask

    task automatic test_contention();
        logic [19:0] exp, got;
        int p;
        for (int c = 0; c <= 33; c++) begin
            @(posedge CLOCK_50); #1;
            if (c == 0) begin
                vga_req = 1'b1; vga_addr = 16'h0200;
                cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h3000; cpu_wdata = 8'h11;
            end
            if (c == 33) begin vga_req = 1'b0; cpu_req = 1'b0; end
            @(negedge CLOCK_50);
            p = (c + 10) % 11;
            if (c == 0)
                exp = 20'd0;
            else
                exp = {p == 0, p == 9, p == 9, p >= 1 && p <= 8,
                       (p <= 7) ? 16'(16'h0200 + p) : (p == 9) ? 16'h3000 : 16'h0000};
            got = {vga_grant, cpu_ready, mem_we, vga_rvalid, mem_addr};
            n_vec++;
            if (got !== exp) begin
                n_err++; $display("FAIL contention c=%0d got %h expected %h", c, got, exp);
            end
        end
    endtask

    task automatic test_addr_wrap();
        logic [27:0] exp, got;
        for (int c = 0; c <= 10; c++) begin
            @(posedge CLOCK_50); #1;
            if (c == 0) begin vga_req = 1'b1; vga_addr = 16'hFFFC; end
            if (c == 2) vga_req = 1'b0;
            @(negedge CLOCK_50);
            exp = {c == 1, c >= 2 && c <= 9, c == 9, (c >= 2 && c <= 9) ? 8'(250 + c) : 8'h00,
                   1'b0, (c >= 1 && c <= 8) ? 16'(65531 + c) : 16'h0000};
            got = {vga_grant, vga_rvalid, vga_done, vga_rdata, mem_we, mem_addr};
            n_vec++;
            if (got !== exp) begin
                n_err++; $display("FAIL addr_wrap c=%0d got %h expected %h", c, got, exp);
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [27:0] exp, got;
        for (int c = 0; c <= 4; c++) begin
            @(posedge CLOCK_50); #1;
            if (c == 0) begin vga_req = 1'b1; vga_addr = 16'h0400; end
            @(negedge CLOCK_50);
        end
        n_vec++;
        if ({mem_addr, vga_rvalid, vga_rdata} !== {16'h0403, 1'b1, 8'h02}) begin
            n_err++; $display("FAIL mid_burst_pre got %h expected %h",
                              {mem_addr, vga_rvalid, vga_rdata}, {16'h0403, 1'b1, 8'h02});
        end
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if (all_out !== 46'd0) begin
            n_err++; $display("FAIL mid_burst_async got %h expected 0", all_out);
        end
        @(posedge CLOCK_50); #1;
        n_vec++;
        if (all_out !== 46'd0) begin
            n_err++; $display("FAIL mid_burst_held got %h expected 0", all_out);
        end
        rst_n = 1'b1;
        @(negedge CLOCK_50);
        n_vec++;
        if (all_out !== 46'd0) begin
            n_err++; $display("FAIL mid_burst_idle got %h expected 0", all_out);
        end
        for (int c = 1; c <= 10; c++) begin
            @(posedge CLOCK_50); #1;
            if (c == 2) vga_req = 1'b0;
            @(negedge CLOCK_50);
            exp = {c == 1, c >= 2 && c <= 9, c == 9, (c >= 2 && c <= 9) ? 8'(c - 2) : 8'h00,
                   1'b0, (c >= 1 && c <= 8) ? 16'(16'h0400 + c - 1) : 16'h0000};
            got = {vga_grant, vga_rvalid, vga_done, vga_rdata, mem_we, mem_addr};
            n_vec++;
            if (got !== exp) begin
                n_err++; $display("FAIL mid_burst_restart c=%0d got %h expected %h", c, got, exp);
            end
        end
    endtask

    task automatic test_cpu_drop();
        logic [19:0] exp, got;
        for (int c = 0; c <= 12; c++) begin
            @(posedge CLOCK_50); #1;
            if (c == 0) begin vga_req = 1'b1; vga_addr = 16'h0500; end
            if (c == 2) begin
                vga_req = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0600;
            end
            if (c == 3) cpu_req = 1'b0;
            @(negedge CLOCK_50);
            exp = {1'b0, 1'b0, c == 1, c == 9,
                   (c >= 1 && c <= 8) ? 16'(16'h0500 + c - 1) : 16'h0000};
            got = {cpu_ready, cpu_rvalid, vga_grant, vga_done, mem_addr};
            n_vec++;
            if (got !== exp) begin
                n_err++; $display("FAIL cpu_drop c=%0d got %h expected %h", c, got, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_vga_burst();
        test_cpu_write_read();
        test_contention();
        test_addr_wrap();
        test_reset_mid_burst();
        test_cpu_drop();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Arbitrates the single-port video RAM between two requesters: the VGA scanout line-fill engine (burst reads) and the LALU CPU memory-mapped framebuffer port (single reads/writes).
- Sits between the CPU bus, the VGA timing/pixel pipeline and the synchronous VRAM.
- VGA gets priority for deadline safety. CPU waiting time is bounded by strict alternation whenever both requesters are pending.

Parameters:
- ADDR_W, 16, VRAM address width (word addressed)
- DATA_W, 8, VRAM word width
- VGA_BURST, 8, words read per VGA burst (≥1, ≤ 2^ADDR_W)

Ports:
- CLOCK_50  in  1  system clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- vga_req  in  1  VGA requests a burst; held until vga_grant
- vga_addr  in  ADDR_W  burst base address, sampled in the IDLE cycle that selects VGA
- vga_grant  out  1  one-cycle pulse on the first issue cycle of a burst
- vga_rdata  out  DATA_W  read data; meaningful only while vga_rvalid
- vga_rvalid  out  1  one pulse per burst word, in address order
- vga_done  out  1  pulse coincident with the last vga_rvalid of a burst
- cpu_req  in  1  CPU access request; req/we/addr/wdata held until cpu_ready
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_ready  out  1  one-cycle pulse when the access is issued to VRAM
- cpu_rdata  out  DATA_W  read data; meaningful only while cpu_rvalid
- cpu_rvalid  out  1  pulse one cycle after cpu_ready, reads only
- mem_addr  out  ADDR_W  VRAM address
- mem_we  out  1  VRAM write enable
- mem_wdata  out  DATA_W  VRAM write data
- mem_rdata  in  DATA_W  VRAM read data; synchronous RAM, valid the cycle after the address is presented

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, last_vga=0, burst counter=0, return-tag pipe cleared.
  - All outputs 0: grants, ready, rvalid, done, mem_we, mem_addr, mem_wdata.
- States: IDLE, VGA_RD, CPU_ACC.
- IDLE: one cycle with no VRAM access. Decision:
  - vga_req && !(cpu_req && last_vga) -> VGA_RD; latch base=vga_addr, cnt=0.
  - else cpu_req -> CPU_ACC.
  - else stay in IDLE.
- VGA_RD: one VRAM read per cycle.
  - mem_addr = base+cnt, modulo 2^ADDR_W (wraps at the top of the address space).
  - vga_grant=1 when cnt==0.
  - When cnt==VGA_BURST-1: go to IDLE and set last_vga=1.
  - vga_req is ignored while in VGA_RD.
- CPU_ACC: exactly one cycle, then IDLE.
  - Drives mem_addr=cpu_addr, mem_we=cpu_we, mem_wdata=cpu_wdata.
  - cpu_ready=1; last_vga cleared.
- Read return:
  - A 1-bit tag pipeline (VGA/CPU, plus a last-word flag) delays by one cycle.
  - The cycle after each VGA issue: vga_rvalid=1 (and vga_done on the last word).
  - The cycle after a CPU read issue: cpu_rvalid=1.
  - rdata outputs pass mem_rdata through combinationally. Writes produce no rvalid.
- Pipelining: the return cycle of the last burst word overlaps the following IDLE cycle, so no bubble is added beyond IDLE.
- Latency:
  - Request seen in IDLE at cycle t -> grant/ready at t+1 -> first rvalid at t+2.
  - Last vga_done at t+1+VGA_BURST.
- Fairness bound:
  - CPU waits at most VGA_BURST+2 cycles from IDLE.
  - VGA waits at most 3 cycles when both requesters are continuously pending.
- mem_we is high only in CPU_ACC with cpu_we=1; it is never high in VGA_RD or IDLE.
- Reset mid-burst: the burst is abandoned, with no further rvalid and no vga_done. The VGA engine must re-request.
- A requester dropping req before grant/ready is legal; it simply loses its slot.

Decomposition:
- Shared package vram_pkg holds the state encoding (IDLE/VGA_RD/CPU_ACC localparams) and the default ADDR_W/DATA_W, which the VGA pipeline and CPU bus decoder also use.
- No sub-module is needed. The return-tag pipeline is inline (≈150 lines of RTL).

Test Plan:
- Lone VGA burst:
  - Stimulus: vga_req, vga_addr=0x0100, RAM[0x100+i]=i.
  - Response: grant at t+1; mem_addr 0x100..0x107; rvalid t+2..t+9 with data 0..7; vga_done with data 7.
- Lone CPU write then read:
  - Stimulus: write 0xA5 to 0x1234, then read 0x1234.
  - Response: write cpu_ready with mem_we=1 and no rvalid; read cpu_ready, then cpu_rvalid next cycle with cpu_rdata=0xA5.
- Contention with both requesters held high:
  - Response: order is VGA burst, CPU, VGA burst, CPU, ...
  - CPU ready never more than VGA_BURST+2 cycles after IDLE; mem_we never high during VGA_RD.
- Address wrap:
  - Stimulus: vga_addr=0xFFFC.
  - Response: mem_addr sequence FFFC, FFFD, FFFE, FFFF, 0000, 0001, 0002, 0003.
- Reset mid-burst:
  - Stimulus: assert rst_n=0 asynchronously at cnt=3.
  - Response: all outputs 0 immediately, no vga_done. After release, an IDLE cycle precedes the next grant.
- CPU drops request:
  - Stimulus: cpu_req high for 1 cycle during VGA_RD, then low.
  - Response: no cpu_ready ever; next IDLE serves VGA or idles.
